lutram_fifo16: RTL

//  16-deep synchronous FIFO controller with storage in RAM16X1D cells, one per data bit.

---
 rtl/lutram_fifo16.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/lutram_fifo16.sv
// -----------------------------------------------------------------------------
// lutram_fifo16
//
// A 16-entry synchronous FIFO controller. Storage is built from WIDTH
// RAM16X1D-style distributed RAM cells, with one cell per data bit. Each cell
// has a synchronous write port and an asynchronous read port:
//   - the write pointer addresses the write port (A3..A0)
//   - DIN feeds D
//   - the push strobe drives WE
//   - the read pointer addresses the read port (DPRA3..DPRA0)
//   - the DPO bits together form DOUT (first-word-fall-through)
//
// The FIFO buffers bytes between the nextz80 core's I/O port writes and
// slower peripheral consumers.
//
// Parameters
//   WIDTH     data width, one RAM cell per bit              (default 8)
//   AF_LEVEL  AFULL asserts when COUNT >= AF_LEVEL (1..16)   (default 12)
//
// Ports
//   CLK    in   1      single clock; RAM write clock is tied to it
//   RST_N  in   1      asynchronous active-low reset
//   CLR    in   1      synchronous flush; overrides push/pop that cycle
//   WR     in   1      push request; DIN captured on the rising edge
//   DIN    in   WIDTH  write data
//   RD     in   1      pop request; DOUT consumed on the rising edge
//   DOUT   out  WIDTH  head-of-queue data, combinational from RAM
//   EMPTY  out  1      no entries
//   FULL   out  1      16 entries
//   AFULL  out  1      COUNT >= AF_LEVEL
//   COUNT  out  5      occupancy, 0..16
//   OVF    out  1      sticky overflow flag  (only with FIFO_ERR_FLAGS_EN)
//   UDF    out  1      sticky underflow flag (only with FIFO_ERR_FLAGS_EN)
//
// Configuration macro
//   FIFO_ERR_FLAGS_EN
//     When defined, the sticky OVF/UDF outputs are added.
//     When undefined, the ports do not exist and errors are silently ignored.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// lutram_ram16x1d
//
// Behavioural equivalent of one RAM16X1D cell, restricted to the ports the
// FIFO uses: 16x1 storage with a synchronous write port and an asynchronous
// read port. The contents have no reset, which matches the real primitive.
//
// Ports
//   WCLK  in   1  write clock
//   WE    in   1  write enable
//   A     in   4  write address
//   D     in   1  write data
//   DPRA  in   4  asynchronous read address
//   DPO   out  1  read data
// -----------------------------------------------------------------------------
module lutram_ram16x1d (
    input  logic       WCLK,
    input  logic       WE,
    input  logic [3:0] A,
    input  logic       D,
    input  logic [3:0] DPRA,
    output logic       DPO
);

    logic [15:0] mem_q;

    always_ff @(posedge WCLK) begin
        if (WE) begin
            mem_q[A] <= D;
        end
    end

    assign DPO = mem_q[DPRA];

endmodule

module lutram_fifo16 #(
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             WR,
    input  logic [WIDTH-1:0] DIN,
    input  logic             RD,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             AFULL,
    output logic [4:0]       COUNT
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             OVF,
    output logic             UDF
`endif
);

    // The threshold is narrowed once to the counter width so that the
    // comparison below is width-matched.
    localparam logic [4:0] AfThresh = 5'(AF_LEVEL);
    localparam logic [4:0] Depth    = 5'd16;

    logic [3:0] wr_ptr_q, wr_ptr_d;
    logic [3:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] count_q,  count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ram_we;

    assign full  = (count_q == Depth);
    assign empty = (count_q == 5'd0);

    // A full FIFO still accepts a push when a pop frees the head slot in the
    // same cycle. The old head is read asynchronously before the edge, and
    // the slot is overwritten on that edge. An empty FIFO cannot pop, so
    // RD+WR on empty degenerates to a plain push.
    assign push = WR & (~full | RD);
    assign pop  = RD & ~empty;

    // A flush must never land a write in RAM, even though it discards the
    // pointers anyway.
    assign ram_we = push & ~CLR;

    // -------------------------------------------------------------------------
    // Next-state logic for the pointers and the occupancy counter.
    // CLR overrides everything. Otherwise each pointer advances on its own
    // strobe and wraps naturally through its 4-bit width. The counter moves
    // only when exactly one of push/pop happens.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (CLR) begin
            wr_ptr_d = 4'd0;
            rd_ptr_d = 4'd0;
            count_d  = 5'd0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 4'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 4'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control state registers. The RAM contents are deliberately left out of
    // the reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= 4'd0;
            rd_ptr_q <= 4'd0;
            count_q  <= 5'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: one 16x1 distributed RAM cell per data bit, all sharing the
    // same addresses and write strobe.
    // -------------------------------------------------------------------------
    genvar gBit;
    generate
        for (gBit = 0; gBit < WIDTH; gBit++) begin : g_ram
            lutram_ram16x1d u_cell (
                .WCLK (CLK),
                .WE   (ram_we),
                .A    (wr_ptr_q),
                .D    (DIN[gBit]),
                .DPRA (rd_ptr_q),
                .DPO  (DOUT[gBit])
            );
        end
    endgenerate

    assign EMPTY = empty;
    assign FULL  = full;
    assign AFULL = (count_q >= AfThresh);
    assign COUNT = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // -------------------------------------------------------------------------
    // Sticky error flags. A WR that is not accepted raises OVF, and RD on an
    // empty FIFO raises UDF; RD+WR on empty still counts as an underflow
    // attempt. Each flag becomes visible one edge after the offending cycle.
    // CLR clears both flags and wins over a simultaneous error.
    // -------------------------------------------------------------------------
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (CLR) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (WR && !push) begin
                ovf_d = 1'b1;
            end
            if (RD && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`endif

endmodule
